range_ud_bounce_counter: RTL and testbench

- Parametrised up/down loadable counter confined to a runtime window [lo, hi].
- Three boundary modes: wrap, saturate, and bounce (ping-pong, auto-reversing direction).
- Registered terminal-count pulse and config-error flag.
- General-purpose timing/sequencing primitive for address sweeps, PWM ramps and test pattern generation.

---
 rtl/range_cnt_pkg.sv | 20 ++
 rtl/range_cnt_next.sv | 56 +++++
 rtl/range_ud_bounce_counter.sv | 95 +++++++++
 tb/tb_range_ud_bounce_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/range_cnt_pkg.sv
// Shared mode encoding and window clamp for the range_ud_bounce_counter slice.
package range_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Operands are zero-extended to 32 bits so one function serves every WIDTH.
    function automatic logic [31:0] clamp(input logic [31:0] v,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/range_cnt_next.sv
// Combinational next-state for the windowed counter: step, boundary handling and tc.
module range_cnt_next
    import range_cnt_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] count,
    input  logic             d,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             en,
    output logic [WIDTH-1:0] next_count,
    output logic             next_dir,
    output logic             next_tc
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        next_count = count;
        next_dir   = d;
        next_tc    = 1'b0;
        if (en && mode != MODE_HOLD) begin
            if (count < lo || count > hi) begin
                next_count = d ? lo : hi;
            end else if (lo == hi) begin
                next_tc = 1'b1;
                if (mode == MODE_BOUNCE) next_dir = ~d;
            end else if (d && count == hi) begin
                next_tc = 1'b1;
                case (mode)
                    MODE_WRAP:   next_count = lo;
                    MODE_BOUNCE: begin
                        next_count = hi - 1'b1;
                        next_dir   = 1'b0;
                    end
                    default: ;
                endcase
            end else if (!d && count == lo) begin
                next_tc = 1'b1;
                case (mode)
                    MODE_WRAP:   next_count = hi;
                    MODE_BOUNCE: begin
                        next_count = lo + 1'b1;
                        next_dir   = 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                // Bound compares above guarantee these never overflow WIDTH.
                next_count = d ? count + 1'b1 : count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/range_ud_bounce_counter.sv
// Up/down loadable counter confined to [lo, hi] with wrap/saturate/bounce modes.
// Optional wrap event counter output enabled by RANGE_UD_BOUNCE_COUNTER_WRAP_CNT_EN.
module range_ud_bounce_counter
    import range_cnt_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int WC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    data,
    input  logic                u_d,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    count,
    output logic                dir,
    output logic                tc,
    output logic                cfg_err
`ifdef RANGE_UD_BOUNCE_COUNTER_WRAP_CNT_EN
    ,
    output logic [WC_WIDTH-1:0] wrap_cnt
`endif
);

    if (WIDTH < 2 || WIDTH > 32 || WC_WIDTH < 1) begin : g_bad_param
        $error("range_ud_bounce_counter: WIDTH must be 2..32 and WC_WIDTH >= 1");
    end

    mode_e            mode_q;
    logic             bad_bounds;
    logic             d;
    logic [WIDTH-1:0] next_count;
    logic             next_dir;
    logic             next_tc;
    logic [WIDTH-1:0] load_value;

    assign mode_q     = mode_e'(mode);
    assign bad_bounds = (lo > hi);
    // Bounce mode steers from its own direction register; other modes follow u_d.
    assign d          = (mode_q == MODE_BOUNCE) ? dir : u_d;
    assign load_value = WIDTH'(clamp(32'(data), 32'(lo), 32'(hi)));

    range_cnt_next #(.WIDTH(WIDTH)) u_next (
        .count      (count),
        .d          (d),
        .mode       (mode_q),
        .lo         (lo),
        .hi         (hi),
        .en         (en),
        .next_count (next_count),
        .next_dir   (next_dir),
        .next_tc    (next_tc)
    );

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= '0;
            dir     <= 1'b1;
            tc      <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= bad_bounds;
            if (bad_bounds) begin
                tc <= 1'b0;
                if (mode_q != MODE_BOUNCE) dir <= u_d;
            end else if (load) begin
                count <= load_value;
                dir   <= u_d;
                tc    <= 1'b0;
            end else begin
                count <= next_count;
                dir   <= next_dir;
                tc    <= next_tc;
            end
        end
    end

`ifdef RANGE_UD_BOUNCE_COUNTER_WRAP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_cnt <= '0;
        end else if (!bad_bounds) begin
            if (load)
                wrap_cnt <= '0;
            else if (next_tc && wrap_cnt != '1)
                wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_range_ud_bounce_counter.sv
// Directed bench for range_ud_bounce_counter with an arithmetic reference model
// compared every cycle, plus literal checks that pin the model.
module tb_range_ud_bounce_counter;

    localparam int WIDTH    = 6;
    localparam int WC_WIDTH = 8;
    localparam int WC_MAX   = (1 << WC_WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst, en, load, u_d;
    logic [WIDTH-1:0] data, lo, hi;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             dir, tc, cfg_err;
`ifdef RANGE_UD_BOUNCE_COUNTER_WRAP_CNT_EN
    logic [WC_WIDTH-1:0] wrap_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    range_ud_bounce_counter #(.WIDTH(WIDTH), .WC_WIDTH(WC_WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .data    (data),
        .u_d     (u_d),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .count   (count),
        .dir     (dir),
        .tc      (tc),
        .cfg_err (cfg_err)
`ifdef RANGE_UD_BOUNCE_COUNTER_WRAP_CNT_EN
        ,
        .wrap_cnt(wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window arithmetic on plain integers.
    typedef struct {
        int count;
        bit dir;
        bit tc;
        bit cfg;
        int wc;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, int ilo, int ihi, int idata,
                                           bit ien, bit iload, bit iud, int imode);
        mstate_t n = s;
        int span = ihi - ilo + 1;
        int t;
        bit d;
        n.tc  = 1'b0;
        n.cfg = (ilo > ihi);
        if (ilo > ihi) begin
            if (imode != 2) n.dir = iud;
            return n;
        end
        if (iload) begin
            n.count = (idata < ilo) ? ilo : ((idata > ihi) ? ihi : idata);
            n.dir   = iud;
            n.wc    = 0;
            return n;
        end
        d     = (imode == 2) ? s.dir : iud;
        n.dir = d;
        if (!ien || imode == 3) return n;
        if (s.count < ilo || s.count > ihi) begin
            n.count = d ? ilo : ihi;
            return n;
        end
        t = s.count + (d ? 1 : -1);
        if (t >= ilo && t <= ihi) begin
            n.count = t;
            return n;
        end
        n.tc = 1'b1;
        if (n.wc < WC_MAX) n.wc = n.wc + 1;
        case (imode)
            0: n.count = ilo + (((t - ilo) % span) + span) % span;
            2: begin
                n.dir = ~d;
                if (span > 1) n.count = (t > ihi) ? 2 * ihi - t : 2 * ilo - t;
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst)
            m <= '{count: 0, dir: 1'b1, tc: 1'b0, cfg: 1'b0, wc: 0};
        else
            m <= model_next(m, int'(lo), int'(hi), int'(data), en, load, u_d, int'(mode));
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cmp_count", 32'(count), 32'(m.count));
            check("cmp_dir", 32'(dir), 32'(m.dir));
            check("cmp_tc", 32'(tc), 32'(m.tc));
            check("cmp_cfg_err", 32'(cfg_err), 32'(m.cfg));
`ifdef RANGE_UD_BOUNCE_COUNTER_WRAP_CNT_EN
            check("cmp_wrap_cnt", 32'(wrap_cnt), 32'(m.wc));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal expectations on DUT outputs and on the model itself.
    task automatic expect_ct(input string tag, input int c, input bit t);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_tc"}, 32'(tc), 32'(t));
        check({tag, "_model_count"}, 32'(m.count), 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int b_exp[12] = '{20, 19, 18, 17, 16, 15, 14, 13, 12, 11, 10, 11};

    initial begin
        rst = 1'b0; en = 1'b1; load = 1'b0; data = '0; u_d = 1'b1;
        mode = 2'b00; lo = 6'd10; hi = 6'd20;

        // 1. reset held two clocks with en=1
        tick();
        checking = 1'b1;
        tick();
        expect_ct("reset", 0, 1'b0);
        check("reset_dir", 32'(dir), 32'd1);
        check("reset_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b1; en = 1'b0;
        tick(); tick();
        expect_ct("post_reset_hold", 0, 1'b0);

        // 2. wrap up
        mode = 2'b00; u_d = 1'b1; load = 1'b1; data = 6'd18;
        tick();
        expect_ct("wrap_load", 18, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); expect_ct("wrap_19", 19, 1'b0);
        tick(); expect_ct("wrap_20", 20, 1'b0);
        tick(); expect_ct("wrap_to_lo", 10, 1'b1);
        tick(); expect_ct("wrap_11", 11, 1'b0);
        en = 1'b0;

        // 3. saturate down
        mode = 2'b01; u_d = 1'b0; load = 1'b1; data = 6'd12;
        tick(); expect_ct("sat_load", 12, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); expect_ct("sat_11", 11, 1'b0);
        tick(); expect_ct("sat_10", 10, 1'b0);
        tick(); expect_ct("sat_hold1", 10, 1'b1);
        tick(); expect_ct("sat_hold2", 10, 1'b1);
        en = 1'b0;

        // 4. bounce, u_d toggling must be ignored
        mode = 2'b10; u_d = 1'b1; load = 1'b1; data = 6'd19;
        tick(); expect_ct("bnc_load", 19, 1'b0);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            u_d = k[0];
            tick();
            expect_ct($sformatf("bnc_%0d", k), b_exp[k], (k == 1 || k == 11));
            if (k == 1)  check("bnc_dir_down", 32'(dir), 32'd0);
            if (k == 11) check("bnc_dir_up", 32'(dir), 32'd1);
        end

        // 5. clamp on load, out-of-window recovery, degenerate window
        mode = 2'b00; en = 1'b0; u_d = 1'b1; load = 1'b1;
        data = 6'd40; tick(); expect_ct("clamp_hi", 20, 1'b0);
        data = 6'd5;  tick(); expect_ct("clamp_lo", 10, 1'b0);
        data = 6'd40; tick(); expect_ct("clamp_hi2", 20, 1'b0);
        load = 1'b0; lo = 6'd25; hi = 6'd30; en = 1'b1;
        tick(); expect_ct("oow_to_lo", 25, 1'b0);
        mode = 2'b10; lo = 6'd7; hi = 6'd7;
        tick(); expect_ct("single_enter", 7, 1'b0);
        tick(); expect_ct("single_a", 7, 1'b1);
        check("single_dir_a", 32'(dir), 32'd0);
        tick(); expect_ct("single_b", 7, 1'b1);
        check("single_dir_b", 32'(dir), 32'd1);
        tick(); expect_ct("single_c", 7, 1'b1);

        // 6. config error freezes count and ignores load
        mode = 2'b00; lo = 6'd10; hi = 6'd20; en = 1'b0; load = 1'b1; data = 6'd15;
        tick(); expect_ct("cfg_pre", 15, 1'b0);
        lo = 6'd30; hi = 6'd10; data = 6'd3; en = 1'b1;
        tick(); expect_ct("cfg_hold1", 15, 1'b0);
        check("cfg_err_set", 32'(cfg_err), 32'd1);
        tick(); expect_ct("cfg_hold2", 15, 1'b0);
        lo = 6'd10; hi = 6'd20; load = 1'b0; u_d = 1'b1;
        tick(); expect_ct("cfg_resume", 16, 1'b0);
        check("cfg_err_clr", 32'(cfg_err), 32'd0);
        tick(); expect_ct("cfg_resume2", 17, 1'b0);

        // Mixed sweep over every mode in a narrow window; model-compared only.
        lo = 6'd3; hi = 6'd8;
        for (int i = 0; i < 80; i++) begin
            mode = 2'((i / 20) % 4);
            u_d  = ((i % 7) < 4);
            en   = ((i % 5) != 0);
            load = ((i % 13) == 0);
            data = 6'(i);
            tick();
        end

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
